// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI frame sequencer.
// The TIMEOUT/ABORT machinery exists only when SPI_CTRL_WDT_EN is defined.
package spi_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned WDT_W  = 16;

    localparam logic [7:0]        STATUS_MAGIC = 8'hA5;
    localparam logic [15:0]       ERR_MAGIC    = 16'hBAD0;
    localparam logic [ADDR_W-1:0] ADDR_ERR_CLR = 6'h3F;
    localparam logic [CNT_W-1:0]  FRAME_BITS   = 6'd32;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_STATUS = 2'b11
    } op_e;

    typedef enum logic [7:0] {
        ERR_NONE    = 8'h00,
        ERR_BITCNT  = 8'h01,
        ERR_ADDR    = 8'h02,
        ERR_OVERRUN = 8'h03,
        ERR_TIMEOUT = 8'h04
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DECODE,
        ST_EXEC,
`ifdef SPI_CTRL_WDT_EN
        ST_LOAD,
        ST_ABORT
`else
        ST_LOAD
`endif
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    // Error response word shifted out on MISO.
    function automatic logic [WORD_W-1:0] err_resp(input err_e code);
        return {ERR_MAGIC, 8'h00, code};
    endfunction

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Bus between the SPI pads/shifter and the frame sequencer.
// master: sequencer side; slave: pads/shifter side.
interface spi_frame_ctrl_if;
    import spi_ctrl_pkg::*;

    logic              spi_sclk;
    logic              spi_ss_n;
    logic [WORD_W-1:0] spi_data_out;
    logic [WORD_W-1:0] spi_data_in;
    logic              spi_data_valid_n;
    logic              spi_enable_sn;

    modport master (
        input  spi_sclk, spi_ss_n, spi_data_out,
        output spi_data_in, spi_data_valid_n, spi_enable_sn
    );

    modport slave (
        output spi_sclk, spi_ss_n, spi_data_out,
        input  spi_data_in, spi_data_valid_n, spi_enable_sn
    );

endinterface

// File: rtl/spi_sync_edge.sv
// DEPTH-stage synchronizer with edge pulses taken from the two oldest stages.
module spi_sync_edge #(
    parameter int unsigned DEPTH   = 3,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Bit 0 is the newest sample, bit DEPTH-1 the oldest.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_c =  sync_q[DEPTH-2] & ~sync_q[DEPTH-1];
    assign fall_c = ~sync_q[DEPTH-2] &  sync_q[DEPTH-1];

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame sequencer: tracks chip-select frames, decodes the captured word, runs it against the
// config register bank and preloads the next MISO response. Optional frame watchdog: SPI_CTRL_WDT_EN.
module spi_frame_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned SYNC_DEPTH = 3,
    parameter int unsigned WDT_CYCLES = 65535
) (
    input  logic                       clock,
    input  logic                       reset_n,
    spi_frame_ctrl_if.master           spi,
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
    output logic                       cfg_wr_strobe,
    output logic [ADDR_W-1:0]          cfg_wr_addr,
    output logic                       frame_done,
    output logic                       err_sticky
);

    localparam int unsigned REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic sclk_rise_c;
    logic sclk_fall_unused_c;
    logic ss_rise_c;
    logic ss_fall_c;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]                     bit_cnt_last_q, bit_cnt_last_d;
    frame_t                               word_q, word_d;
    err_e                                 err_code_q, err_code_d;
    logic                                 overrun_q, overrun_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]      cfg_regs_q, cfg_regs_d;
    logic                                 cfg_wr_strobe_q, cfg_wr_strobe_d;
    logic [ADDR_W-1:0]                    cfg_wr_addr_q, cfg_wr_addr_d;
    logic                                 frame_done_q, frame_done_d;
    logic                                 err_sticky_q, err_sticky_d;
    logic [WORD_W-1:0]                    data_in_q, data_in_d;
    logic                                 valid_n_q, valid_n_d;
    logic                                 enable_sn_q, enable_sn_d;

    frame_t                               frame_in_c;
    logic [DATA_W-1:0]                    rd_data_c;
    logic [WORD_W-1:0]                    resp_c;

`ifdef SPI_CTRL_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
`else
    logic unused_wdt_cfg_c;
    assign unused_wdt_cfg_c = |WDT_CYCLES;
`endif

    spi_sync_edge #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clock),
        .rst_n  (reset_n),
        .din    (spi.spi_sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_unused_c)
    );

    spi_sync_edge #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_ss_sync (
        .clk    (clock),
        .rst_n  (reset_n),
        .din    (spi.spi_ss_n),
        .rise_c (ss_rise_c),
        .fall_c (ss_fall_c)
    );

    assign frame_in_c = frame_t'(spi.spi_data_out);

    // Response word for the frame latched in DECODE.
    always_comb begin
        rd_data_c = cfg_regs_q[REG_IDX_W'(word_q.addr)];
        resp_c    = '0;
        case (word_q.op)
            OP_NOP:    resp_c = '0;
            OP_WRITE:  resp_c = word_q;
            OP_READ:   resp_c = {word_q.op, word_q.addr, rd_data_c};
            OP_STATUS: resp_c = {STATUS_MAGIC, 15'b0, err_sticky_q, bit_cnt_last_q, 2'b00};
            default:   resp_c = '0;
        endcase
        if (err_code_q != ERR_NONE) begin
            resp_c = err_resp(err_code_q);
        end
    end

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        bit_cnt_last_d  = bit_cnt_last_q;
        word_d          = word_q;
        err_code_d      = err_code_q;
        overrun_d       = overrun_q;
        cfg_regs_d      = cfg_regs_q;
        cfg_wr_strobe_d = 1'b0;
        cfg_wr_addr_d   = cfg_wr_addr_q;
        frame_done_d    = 1'b0;
        err_sticky_d    = err_sticky_q;
        data_in_d       = data_in_q;
        valid_n_d       = 1'b1;
        enable_sn_d     = 1'b0;
`ifdef SPI_CTRL_WDT_EN
        wdt_cnt_d       = wdt_cnt_q;
`endif

        // Edges are counted in ACTIVE, and also while a follow-on frame overlaps DECODE/EXEC.
        if ((state_q == ST_ACTIVE || overrun_q) && sclk_rise_c && bit_cnt_q != 6'h3F) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall_c) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
`ifdef SPI_CTRL_WDT_EN
                    wdt_cnt_d = '0;
`endif
                end
            end

            ST_ACTIVE: begin
                if (ss_rise_c) begin
                    state_d = ST_DECODE;
                end
`ifdef SPI_CTRL_WDT_EN
                else if (sclk_rise_c) begin
                    wdt_cnt_d = '0;
                end else if (wdt_cnt_q == WDT_LAST) begin
                    state_d    = ST_ABORT;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + 16'd1;
                end
`endif
            end

            ST_DECODE: begin
                word_d         = frame_in_c;
                bit_cnt_last_d = bit_cnt_q;
                state_d        = ST_EXEC;
                if (bit_cnt_q != FRAME_BITS) begin
                    err_code_d = ERR_BITCNT;
                end else if ((frame_in_c.op == OP_READ ||
                              (frame_in_c.op == OP_WRITE && frame_in_c.addr != ADDR_ERR_CLR)) &&
                             32'(frame_in_c.addr) >= NUM_REGS) begin
                    err_code_d = ERR_ADDR;
                end else begin
                    err_code_d = ERR_NONE;
                end
                if (ss_fall_c) begin
                    overrun_d = 1'b1;
                    bit_cnt_d = '0;
                end
            end

`ifdef SPI_CTRL_WDT_EN
            ST_ABORT: begin
                if (ss_rise_c) begin
                    state_d        = ST_EXEC;
                    bit_cnt_last_d = bit_cnt_q;
                end
            end
`endif

            ST_EXEC: begin
                frame_done_d = 1'b1;
                if (err_code_q != ERR_NONE) begin
                    err_sticky_d = 1'b1;
                end else if (word_q.op == OP_WRITE) begin
                    cfg_wr_strobe_d = 1'b1;
                    cfg_wr_addr_d   = word_q.addr;
                    if (32'(word_q.addr) < NUM_REGS) begin
                        cfg_regs_d[REG_IDX_W'(word_q.addr)] = word_q.data;
                    end
                    if (word_q.addr == ADDR_ERR_CLR && word_q.data[0]) begin
                        err_sticky_d = 1'b0;
                    end
                end
                // A new frame already started: keep the commit, drop the preload.
                if (overrun_q || ss_fall_c) begin
                    state_d      = ST_ACTIVE;
                    err_sticky_d = 1'b1;
                    overrun_d    = 1'b0;
                    if (ss_fall_c) begin
                        bit_cnt_d = '0;
                    end
`ifdef SPI_CTRL_WDT_EN
                    wdt_cnt_d = '0;
`endif
                end else begin
                    state_d   = ST_LOAD;
                    valid_n_d = 1'b0;
                    data_in_d = resp_c;
                end
            end

            ST_LOAD: begin
                state_d = ST_IDLE;
                if (ss_fall_c) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
`ifdef SPI_CTRL_WDT_EN
                    wdt_cnt_d = '0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            bit_cnt_last_q  <= '0;
            word_q          <= '0;
            err_code_q      <= ERR_NONE;
            overrun_q       <= 1'b0;
            cfg_regs_q      <= '0;
            cfg_wr_strobe_q <= 1'b0;
            cfg_wr_addr_q   <= '0;
            frame_done_q    <= 1'b0;
            err_sticky_q    <= 1'b0;
            data_in_q       <= '0;
            valid_n_q       <= 1'b1;
            enable_sn_q     <= 1'b1;
`ifdef SPI_CTRL_WDT_EN
            wdt_cnt_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            bit_cnt_last_q  <= bit_cnt_last_d;
            word_q          <= word_d;
            err_code_q      <= err_code_d;
            overrun_q       <= overrun_d;
            cfg_regs_q      <= cfg_regs_d;
            cfg_wr_strobe_q <= cfg_wr_strobe_d;
            cfg_wr_addr_q   <= cfg_wr_addr_d;
            frame_done_q    <= frame_done_d;
            err_sticky_q    <= err_sticky_d;
            data_in_q       <= data_in_d;
            valid_n_q       <= valid_n_d;
            enable_sn_q     <= enable_sn_d;
`ifdef SPI_CTRL_WDT_EN
            wdt_cnt_q       <= wdt_cnt_d;
`endif
        end
    end

    assign spi.spi_data_in      = data_in_q;
    assign spi.spi_data_valid_n = valid_n_q;
    assign spi.spi_enable_sn    = enable_sn_q;
    assign cfg_regs             = cfg_regs_q;
    assign cfg_wr_strobe        = cfg_wr_strobe_q;
    assign cfg_wr_addr          = cfg_wr_addr_q;
    assign frame_done           = frame_done_q;
    assign err_sticky           = err_sticky_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed frames plus random frames against a
// behavioural model of the register bank, sticky error flag and response rules.
module tb_spi_frame_ctrl;

    localparam int unsigned NREGS = 8;
    localparam int unsigned RW    = NREGS * 24;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    spi_frame_ctrl_if spi_if ();

    logic [RW-1:0] cfg_regs;
    logic          cfg_wr_strobe;
    logic [5:0]    cfg_wr_addr;
    logic          frame_done;
    logic          err_sticky;

    spi_frame_ctrl #(.NUM_REGS(NREGS), .SYNC_DEPTH(3), .WDT_CYCLES(100)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .spi           (spi_if.master),
        .cfg_regs      (cfg_regs),
        .cfg_wr_strobe (cfg_wr_strobe),
        .cfg_wr_addr   (cfg_wr_addr),
        .frame_done    (frame_done),
        .err_sticky    (err_sticky)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Pulse monitors, sampled on the inactive edge.
    int          n_load   = 0;
    int          n_strobe = 0;
    int          n_done   = 0;
    logic [31:0] last_resp = '0;
    always @(negedge clock) begin
        if (!spi_if.spi_data_valid_n) begin
            n_load++;
            last_resp = spi_if.spi_data_in;
        end
        if (cfg_wr_strobe) n_strobe++;
        if (frame_done)    n_done++;
    end

    // Reference model state.
    logic [23:0] mregs [NREGS];
    logic        msticky;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [RW-1:0] exp_regs();
        logic [RW-1:0] r;
        for (int i = 0; i < NREGS; i++) r[i*24 +: 24] = mregs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        msticky = 1'b0;
    endtask

    // Expected outcome of one frame with the given number of SCLK rises.
    task automatic model_frame(input logic [31:0] w, input int edges,
                               output logic [31:0] resp, output int exp_wr);
        int          cnt;
        logic [1:0]  op;
        int          addr;
        logic [23:0] data;
        logic [7:0]  err;
        cnt  = (edges > 63) ? 63 : edges;
        op   = w[31:30];
        addr = int'(w[29:24]);
        data = w[23:0];
        err  = 8'h00;
        exp_wr = 0;
        if (cnt != 32) err = 8'h01;
        else if ((op == 2'b01 || op == 2'b10) && addr >= NREGS && !(op == 2'b01 && addr == 63))
            err = 8'h02;
        if (err != 8'h00) begin
            resp    = {16'hBAD0, 8'h00, err};
            msticky = 1'b1;
        end else begin
            case (op)
                2'b00: resp = 32'h0;
                2'b01: begin
                    resp   = w;
                    exp_wr = 1;
                    if (addr < NREGS) mregs[addr] = data;
                    if (addr == 63 && data[0]) msticky = 1'b0;
                end
                2'b10: resp = {op, w[29:24], mregs[addr]};
                default: resp = {8'hA5, 15'b0, msticky, 6'(cnt), 2'b00};
            endcase
        end
    endtask

    task automatic toggle_sclk(input int edges);
        for (int e = 0; e < edges; e++) begin
            spi_if.spi_sclk = 1'b1;
            repeat (4) @(negedge clock);
            spi_if.spi_sclk = 1'b0;
            repeat (4) @(negedge clock);
        end
    endtask

    task automatic run_frame(input logic [31:0] w, input int edges, input string tag);
        logic [31:0] exp_resp;
        int          exp_wr;
        int          l0, s0, d0;
        model_frame(w, edges, exp_resp, exp_wr);
        l0 = n_load; s0 = n_strobe; d0 = n_done;
        @(negedge clock);
        spi_if.spi_data_out = w;
        spi_if.spi_ss_n     = 1'b0;
        repeat (4) @(negedge clock);
        toggle_sclk(edges);
        spi_if.spi_ss_n = 1'b1;
        repeat (12) @(negedge clock);
        check({tag, ":loads"},  RW'(n_load - l0), RW'(1));
        check({tag, ":resp"},   RW'(last_resp), RW'(exp_resp));
        check({tag, ":strobe"}, RW'(n_strobe - s0), RW'(exp_wr));
        check({tag, ":done"},   RW'(n_done - d0), RW'(1));
        check({tag, ":sticky"}, RW'(err_sticky), RW'(msticky));
        check({tag, ":regs"},   cfg_regs, exp_regs());
    endtask

    initial begin
        logic [31:0] dummy;
        int          dwr;
        int          l0, s0, d0;

        spi_if.spi_sclk     = 1'b0;
        spi_if.spi_ss_n     = 1'b1;
        spi_if.spi_data_out = '0;
        model_reset();

        repeat (3) @(negedge clock);
        check("rst:valid_n",   RW'(spi_if.spi_data_valid_n), RW'(1));
        check("rst:data_in",   RW'(spi_if.spi_data_in), RW'(0));
        check("rst:enable_sn", RW'(spi_if.spi_enable_sn), RW'(1));
        check("rst:sticky",    RW'(err_sticky), RW'(0));
        check("rst:regs",      cfg_regs, '0);
        check("rst:strobe",    RW'(cfg_wr_strobe), RW'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("rst:enable_after", RW'(spi_if.spi_enable_sn), RW'(0));

        run_frame(32'h4012_3456, 32, "write0");
        run_frame(32'h8000_0000, 32, "read0");
        run_frame(32'h4100_00FF, 31, "short31");
        run_frame(32'h8900_0000, 32, "read_addr9");
        run_frame(32'h7F00_0001, 32, "clr_sticky");
        run_frame(32'hC000_0000, 32, "status");

        // Chip select re-falls one clock after a WRITE frame ends.
        l0 = n_load; s0 = n_strobe; d0 = n_done;
        @(negedge clock);
        spi_if.spi_data_out = 32'h4200_ABCD;
        spi_if.spi_ss_n     = 1'b0;
        repeat (4) @(negedge clock);
        toggle_sclk(32);
        spi_if.spi_ss_n = 1'b1;
        @(negedge clock);
        spi_if.spi_ss_n = 1'b0;
        repeat (10) @(negedge clock);
        model_frame(32'h4200_ABCD, 32, dummy, dwr);
        msticky = 1'b1;
        check("overrun:loads",  RW'(n_load - l0), RW'(0));
        check("overrun:strobe", RW'(n_strobe - s0), RW'(1));
        check("overrun:done",   RW'(n_done - d0), RW'(1));
        check("overrun:sticky", RW'(err_sticky), RW'(1));
        check("overrun:regs",   cfg_regs, exp_regs());
        // The overlapping frame continues as a STATUS read.
        spi_if.spi_data_out = 32'hC000_0000;
        model_frame(32'hC000_0000, 32, dummy, dwr);
        l0 = n_load;
        toggle_sclk(32);
        spi_if.spi_ss_n = 1'b1;
        repeat (12) @(negedge clock);
        check("overrun:next_loads", RW'(n_load - l0), RW'(1));
        check("overrun:next_resp",  RW'(last_resp), RW'(dummy));

        for (int i = 0; i < 25; i++) begin
            logic [31:0] w;
            int          e;
            int          sel;
            w   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 5)       w[29:24] = 6'($urandom_range(0, 7));
            else if (sel < 7)  w[29:24] = 6'($urandom_range(8, 15));
            else if (sel == 7) w[29:24] = 6'h3F;
            e = ($urandom_range(0, 4) == 0) ? $urandom_range(28, 36) : 32;
            run_frame(w, e, "rand");
        end

        run_frame(32'h4300_1111, 70, "saturate");

`ifdef SPI_CTRL_WDT_EN
        l0 = n_load; s0 = n_strobe; d0 = n_done;
        @(negedge clock);
        spi_if.spi_data_out = 32'h4000_0001;
        spi_if.spi_ss_n     = 1'b0;
        repeat (150) @(negedge clock);
        spi_if.spi_ss_n = 1'b1;
        repeat (12) @(negedge clock);
        msticky = 1'b1;
        check("wdt:loads",  RW'(n_load - l0), RW'(1));
        check("wdt:resp",   RW'(last_resp), RW'(32'hBAD0_0004));
        check("wdt:strobe", RW'(n_strobe - s0), RW'(0));
        check("wdt:done",   RW'(n_done - d0), RW'(1));
        check("wdt:sticky", RW'(err_sticky), RW'(1));
`endif

        // Asynchronous reset in the middle of a frame.
        run_frame(32'h4500_BEEF, 32, "pre_reset");
        @(negedge clock);
        spi_if.spi_data_out = 32'h4600_1234;
        spi_if.spi_ss_n     = 1'b0;
        repeat (4) @(negedge clock);
        toggle_sclk(5);
        #2 reset_n = 1'b0;
        #1;
        check("midrst:regs",      cfg_regs, '0);
        check("midrst:sticky",    RW'(err_sticky), RW'(0));
        check("midrst:valid_n",   RW'(spi_if.spi_data_valid_n), RW'(1));
        check("midrst:enable_sn", RW'(spi_if.spi_enable_sn), RW'(1));
        check("midrst:data_in",   RW'(spi_if.spi_data_in), RW'(0));
        spi_if.spi_ss_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("midrst:enable_after", RW'(spi_if.spi_enable_sn), RW'(0));
        run_frame(32'h8000_0000, 32, "post_reset_read");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
